hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline control block for the 5-stage RV32I core.
- Handles the hazards that forwarding cannot resolve: load-use, data-memory wait and taken-branch/jump redirect.
- Drives stall, bubble and flush controls into the PC, IF/ID, ID/EX and EX/MEM registers.
- Sits beside the forwarding unit and consumes the same ID/EX register-address and opcode fields.

Parameters:
- FLUSH_CYCLES, 1: cycles of IF/ID flush plus ID/EX bubble after a redirect; legal range 1..3.
- MAX_WAIT, 255: data-memory wait cycles before a timeout is declared; legal range 1..65535.
- LOAD_OP, 7'b0000011: EX-stage opcode that identifies a load.

Ports:
- CLK  in  1  core clock; all state updates on the posedge.
- RST  in  1  reset; synchronous, active-high.
- id_rs1  in  5  rs1 address of the instruction in ID.
- id_rs2  in  5  rs2 address of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination address of the instruction in EX.
- ex_op  in  7  opcode of the instruction in EX.
- ex_regWrite  in  1  EX instruction writes the register file.
- br_taken  in  1  EX resolved a taken branch, JAL or JALR; one-cycle pulse.
- mem_req  in  1  MEM stage has a load/store outstanding this cycle.
- mem_ready  in  1  data memory completes the current request.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold IF/ID.
- idex_stall  out  1  hold ID/EX.
- exmem_stall  out  1  hold EX/MEM.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  load a NOP into IF/ID.
- mem_timeout  out  1  sticky error: MAX_WAIT exceeded.
- hz_state  out  2  current FSM state, for debug.

Behaviour:
- Outputs are Mealy: combinational from state and inputs, so a stall takes effect in the same cycle the hazard is detected.
- All state is registered on posedge CLK.
- Reset: while RST=1, every output is 0, state = RUN, all counters are 0, pending_br = 0 and mem_timeout is cleared.
- Reset mid-stall or mid-flush aborts immediately; the first cycle after RST falls is RUN.
- Load-use condition: ex_op==LOAD_OP && ex_regWrite && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2, FLUSH=3.
- RUN, checked in priority order:
  - (a) mem_req && !mem_ready: assert pc_stall, ifid_stall, idex_stall and exmem_stall. Load wait_cnt=1 and pending_br=br_taken. Go to MEM_WAIT.
  - (b) br_taken: assert ifid_flush and idex_bubble. If FLUSH_CYCLES>1, load flush_cnt=FLUSH_CYCLES-1 and go to FLUSH; else stay in RUN.
  - (c) load-use: assert pc_stall, ifid_stall and idex_bubble for exactly 1 cycle, then go to LOAD_STALL.
  - Otherwise all outputs are 0.
- LOAD_STALL:
  - Load-use detection is suppressed; EX holds the bubble.
  - Rules (a) and (b) apply as in RUN.
  - Otherwise return to RUN with no stall, so the load and its consumer are separated by exactly 1 bubble.
- MEM_WAIT:
  - All four stall outputs stay high until mem_ready=1.
  - wait_cnt increments each cycle and saturates.
  - A br_taken seen here sets pending_br; br_taken is not re-sampled from EX because EX is frozen.
  - On the mem_ready cycle the stalls deassert that same cycle. If pending_br=1, apply rule (b) that cycle and clear pending_br; otherwise go to RUN.
  - If wait_cnt reaches MAX_WAIT without mem_ready, set mem_timeout, deassert the stalls and return to RUN. mem_timeout stays set until RST.
- FLUSH:
  - Assert ifid_flush and idex_bubble; decrement flush_cnt; return to RUN when it reaches 0.
  - A new br_taken reloads flush_cnt.
  - mem_req && !mem_ready preempts to MEM_WAIT and drops the remaining flush cycles, since the wrong-path instructions are already squashed.
- Simultaneous events: memory wait beats redirect, and redirect beats load-use (the load-use consumer is on the squashed path).
- Register x0 never causes a hazard.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds output ports load_stall_cnt[31:0], mem_stall_cnt[31:0] and flush_cnt_total[31:0].
  - Each counter increments once per cycle in which its cause asserts a stall or flush.
  - Each counter wraps modulo 2^32 and clears on RST.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - the hz_state_t enum (RUN, LOAD_STALL, MEM_WAIT, FLUSH);
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL and OP_JALR;
  - the x0 constant REG_ZERO.
- The forwarding unit imports the same package.
- One sub-module: hz_wait_timer, a loadable, saturating MAX_WAIT counter with a terminal-count flag, reused for flush_cnt with a different width.

Test Plan:
- Load-use: ex_op=0000011, ex_rd=5, ex_regWrite=1, id_rs1=5, id_use_rs1=1 -> pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle, then all outputs 0 with the same ID instruction. Repeat with ex_rd=0 -> no stall.
- Branch vs load-use same cycle: br_taken=1 together with the load-use condition -> ifid_flush=idex_bubble=1, pc_stall=0. With FLUSH_CYCLES=2, flush lasts 2 cycles and hz_state goes 3 then 0.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all four stalls high for 4 cycles and low on the ready cycle. A br_taken pulse in wait cycle 2 -> flush asserted on the ready cycle.
- Timeout: MAX_WAIT=8, mem_ready held 0 -> stalls drop and mem_timeout=1 after cycle 8; mem_timeout holds until RST.
- Reset mid-MEM_WAIT: RST=1 for 1 cycle in wait cycle 3 -> all outputs 0, hz_state=0, mem_timeout=0, pending branch discarded.
- HAZARD_PERF_EN: 3 load-use events, one 5-cycle memory wait and one redirect -> load_stall_cnt=3, mem_stall_cnt=5, flush_cnt_total=FLUSH_CYCLES.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
//   Definitions shared by the pipeline control blocks, i.e. the hazard stall
//   unit and the forwarding unit.
//   - hz_state_t : hazard FSM state encoding (also visible on the hz_state debug port)
//   - OP_*       : RV32I major opcodes used by the control blocks
//   - REG_ZERO   : address of x0, which never carries a dependency
//   - src_hit()  : whether an enabled source operand matches a non-x0 destination
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } hz_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] REG_ZERO  = 5'd0;

  // A source operand depends on rd only if it is actually read and rd is not x0.
  function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                   input logic [4:0] rd);
    return use_src && (src == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/hz_wait_timer.sv
// hz_wait_timer
//   Loadable saturating counter with a terminal-count flag. Counts up and
//   saturates at SAT_VALUE, or counts down and saturates at 0 (COUNT_DOWN=1).
//   Ports:
//     CLK      in  clock
//     RST      in  synchronous active-high reset, clears the count
//     load     in  load load_val (takes priority over step)
//     load_val in  value to load
//     step     in  advance the count by one
//     tc       out count currently equals TC_VALUE
module hz_wait_timer #(
  parameter int unsigned WIDTH      = 16,
  parameter bit          COUNT_DOWN = 1'b0,
  parameter int unsigned SAT_VALUE  = 255,
  parameter int unsigned TC_VALUE   = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic             tc
);

  localparam logic [WIDTH-1:0] SAT_W = WIDTH'(SAT_VALUE);
  localparam logic [WIDTH-1:0] TC_W  = WIDTH'(TC_VALUE);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(0);

  logic [WIDTH-1:0] count_r;

  // Count register: reset, load, or saturating step in the configured direction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_r <= ZERO_W;
    end else if (load) begin
      count_r <= load_val;
    end else if (step) begin
      if (COUNT_DOWN) begin
        if (count_r != ZERO_W) begin
          count_r <= count_r - ONE_W;
        end
      end else begin
        if (count_r < SAT_W) begin
          count_r <= count_r + ONE_W;
        end
      end
    end
  end

  // Terminal-count flag.
  always_comb begin
    if (count_r == TC_W) begin
      tc = 1'b1;
    end else begin
      tc = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline control for hazards forwarding cannot resolve: load-use,
//   data-memory wait and taken-branch/jump redirect. Outputs are Mealy so a
//   stall or flush takes effect in the cycle the hazard is seen.
//   Ports:
//     CLK, RST                  clock, synchronous active-high reset
//     id_rs1/rs2, id_use_rs1/2  source operands of the instruction in ID
//     ex_rd, ex_op, ex_regWrite destination/opcode of the instruction in EX
//     br_taken                  EX resolved a taken redirect (1-cycle pulse)
//     mem_req, mem_ready        MEM request outstanding / completing
//     pc_stall .. exmem_stall   hold controls for PC and pipeline registers
//     idex_bubble, ifid_flush   NOP insertion into ID/EX and IF/ID
//     mem_timeout               sticky: memory wait exceeded MAX_WAIT
//     hz_state                  FSM state for debug
//   Optional: define HAZARD_PERF_EN to add load_stall_cnt, mem_stall_cnt and
//   flush_cnt_total performance counters (32-bit, wrapping).
module hazard_stall_unit
  import core_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MAX_WAIT     = 255,
  parameter logic [6:0]  LOAD_OP      = OP_LOAD
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic [6:0] ex_op,
  input  logic       ex_regWrite,
  input  logic       br_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       mem_timeout,
  output logic [1:0] hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] load_stall_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt_total
`endif
);

  localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

  hz_state_t state_r, state_nxt_s;
  logic pending_br_r, pending_nxt_s;
  logic timeout_r, timeout_set_s, timeout_now_s;
  logic wait_load_s, wait_step_s, wait_tc_s;
  logic flush_load_s, flush_step_s, flush_last_s;
  logic mem_hold_s, load_use_s, mw_branch_s;
  logic mem_stall_s, flush_s, lu_stall_s;

  assign mem_hold_s  = mem_req && !mem_ready;
  assign load_use_s  = (ex_op == LOAD_OP) && ex_regWrite &&
                       (src_hit(id_use_rs1, id_rs1, ex_rd) || src_hit(id_use_rs2, id_rs2, ex_rd));
  // EX is frozen during the wait, so a redirect seen at any point of it is owed.
  assign mw_branch_s = pending_br_r || br_taken;

  hz_wait_timer #(
    .WIDTH(16), .COUNT_DOWN(1'b0), .SAT_VALUE(MAX_WAIT), .TC_VALUE(MAX_WAIT)
  ) u_wait_timer (
    .CLK(CLK), .RST(RST), .load(wait_load_s), .load_val(16'd1),
    .step(wait_step_s), .tc(wait_tc_s)
  );

  // Flush counter holds the remaining flush cycles; tc marks the final one.
  hz_wait_timer #(
    .WIDTH(2), .COUNT_DOWN(1'b1), .SAT_VALUE(3), .TC_VALUE(1)
  ) u_flush_timer (
    .CLK(CLK), .RST(RST), .load(flush_load_s), .load_val(2'(FLUSH_CYCLES - 1)),
    .step(flush_step_s), .tc(flush_last_s)
  );

  // State register plus the pending-branch and sticky timeout flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= RUN;
      pending_br_r <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      pending_br_r <= pending_nxt_s;
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end
    end
  end

  // Next-state and counter-control decode; memory wait beats redirect beats load-use.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_br_r;
    wait_load_s   = 1'b0;
    wait_step_s   = 1'b0;
    flush_load_s  = 1'b0;
    flush_step_s  = 1'b0;
    timeout_set_s = 1'b0;
    case (state_r)
      RUN, LOAD_STALL: begin
        if (mem_hold_s) begin
          state_nxt_s   = MEM_WAIT;
          wait_load_s   = 1'b1;
          pending_nxt_s = br_taken;
        end else if (br_taken) begin
          if (MULTI_FLUSH) begin
            flush_load_s = 1'b1;
            state_nxt_s  = FLUSH;
          end else begin
            state_nxt_s  = RUN;
          end
        end else if ((state_r == RUN) && load_use_s) begin
          state_nxt_s = LOAD_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          pending_nxt_s = 1'b0;
          if (mw_branch_s && MULTI_FLUSH) begin
            flush_load_s = 1'b1;
            state_nxt_s  = FLUSH;
          end else begin
            state_nxt_s  = RUN;
          end
        end else if (wait_tc_s) begin
          timeout_set_s = 1'b1;
          pending_nxt_s = 1'b0;
          state_nxt_s   = RUN;
        end else begin
          wait_step_s   = 1'b1;
          pending_nxt_s = mw_branch_s;
        end
      end
      FLUSH: begin
        if (mem_hold_s) begin
          // Wrong-path instructions are already squashed; drop the remaining flush.
          state_nxt_s   = MEM_WAIT;
          wait_load_s   = 1'b1;
          pending_nxt_s = br_taken;
        end else if (br_taken) begin
          flush_load_s = 1'b1;
          state_nxt_s  = FLUSH;
        end else if (flush_last_s) begin
          flush_step_s = 1'b1;
          state_nxt_s  = RUN;
        end else begin
          flush_step_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s   = RUN;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // Output decode: which cause is asserting a stall, flush or timeout this cycle.
  always_comb begin
    mem_stall_s   = 1'b0;
    flush_s       = 1'b0;
    lu_stall_s    = 1'b0;
    timeout_now_s = 1'b0;
    case (state_r)
      RUN, LOAD_STALL: begin
        if (mem_hold_s) begin
          mem_stall_s = 1'b1;
        end else if (br_taken) begin
          flush_s = 1'b1;
        end else if ((state_r == RUN) && load_use_s) begin
          lu_stall_s = 1'b1;
        end else begin
          mem_stall_s = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          flush_s = mw_branch_s;
        end else if (wait_tc_s) begin
          timeout_now_s = 1'b1;
        end else begin
          mem_stall_s = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_hold_s) begin
          mem_stall_s = 1'b1;
        end else begin
          flush_s = 1'b1;
        end
      end
      default: begin
        mem_stall_s = 1'b0;
      end
    endcase
  end

  assign pc_stall    = !RST && (mem_stall_s || lu_stall_s);
  assign ifid_stall  = !RST && (mem_stall_s || lu_stall_s);
  assign idex_stall  = !RST && mem_stall_s;
  assign exmem_stall = !RST && mem_stall_s;
  assign idex_bubble = !RST && (flush_s || lu_stall_s);
  assign ifid_flush  = !RST && flush_s;
  assign mem_timeout = !RST && (timeout_r || timeout_now_s);
  assign hz_state    = RST ? 2'd0 : state_r;

`ifdef HAZARD_PERF_EN
  logic [31:0] load_stall_cnt_r, mem_stall_cnt_r, flush_cnt_total_r;

  // Per-cause stall/flush cycle counters, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      load_stall_cnt_r  <= 32'd0;
      mem_stall_cnt_r   <= 32'd0;
      flush_cnt_total_r <= 32'd0;
    end else begin
      load_stall_cnt_r  <= load_stall_cnt_r  + {31'd0, lu_stall_s};
      mem_stall_cnt_r   <= mem_stall_cnt_r   + {31'd0, mem_stall_s};
      flush_cnt_total_r <= flush_cnt_total_r + {31'd0, flush_s};
    end
  end

  assign load_stall_cnt  = load_stall_cnt_r;
  assign mem_stall_cnt   = mem_stall_cnt_r;
  assign flush_cnt_total = flush_cnt_total_r;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;
  import core_ctrl_pkg::*;

  localparam int unsigned FC = 2;
  localparam int unsigned MW = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_regWrite, br_taken, mem_req, mem_ready;
  logic [6:0] ex_op;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble, ifid_flush, mem_timeout;
  logic [1:0] hz_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] load_stall_cnt, mem_stall_cnt, flush_cnt_total;
`endif

  int checks = 0;
  int failures = 0;

  hazard_stall_unit #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW), .LOAD_OP(OP_LOAD)) dut (
    .CLK(CLK), .RST(RST),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_op(ex_op), .ex_regWrite(ex_regWrite), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .mem_timeout(mem_timeout), .hz_state(hz_state)
`ifdef HAZARD_PERF_EN
    , .load_stall_cnt(load_stall_cnt), .mem_stall_cnt(mem_stall_cnt),
    .flush_cnt_total(flush_cnt_total)
`endif
  );

  always #5 CLK = ~CLK;

  // {pc, ifid_stall, idex_stall, exmem_stall, bubble, flush, timeout, hz_state[1:0]}
  function automatic logic [8:0] obs();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble, ifid_flush,
            mem_timeout, hz_state};
  endfunction

  task automatic idle_inputs();
    RST = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_op = 7'd0; ex_regWrite = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_op = OP_LOAD; ex_regWrite = 1'b1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1; mem_req = 1'b1; br_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (obs() !== 9'd0) begin
        failures++; $display("FAIL reset_c%0d got=%b exp=%b", i, obs(), 9'd0);
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    logic [8:0] exp_v [3];
    exp_v[0] = 9'b110010000; exp_v[1] = 9'b000000001; exp_v[2] = 9'b000000000;
    idle_inputs();
    set_load_use(5'd5);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ex_regWrite = 1'b0;  // EX now holds the bubble
      #2;
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL load_use_c%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      @(negedge CLK);
    end
    set_load_use(5'd0);
    #2;
    checks++;
    if (obs() !== 9'd0) begin
      failures++; $display("FAIL load_use_x0 got=%b exp=%b", obs(), 9'd0);
    end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_branch_vs_load_use();
    logic [8:0] exp_v [3];
    exp_v[0] = 9'b000011000; exp_v[1] = 9'b000011011; exp_v[2] = 9'b000000000;
    idle_inputs();
    set_load_use(5'd7);
    br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) br_taken = 1'b0;
      if (i == 2) idle_inputs();
      #2;
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL branch_vs_lu_c%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_mem_wait();
    logic [8:0] exp_v [7];
    exp_v[0] = 9'b111100000; exp_v[1] = 9'b111100010; exp_v[2] = 9'b111100010;
    exp_v[3] = 9'b111100010; exp_v[4] = 9'b000011010; exp_v[5] = 9'b000011011;
    exp_v[6] = 9'b000000000;
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      br_taken  = (i == 1);
      mem_ready = (i == 4);
      if (i >= 5) mem_req = 1'b0;
      #2;
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL mem_wait_c%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic [8:0] exp_v;
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < MW)       exp_v = (i == 0) ? 9'b111100000 : 9'b111100010;
      else if (i == MW) exp_v = 9'b000000110;
      else              exp_v = 9'b000000100;
      if (i > MW) mem_req = 1'b0;
      #2;
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL timeout_c%0d got=%b exp=%b", i, obs(), exp_v);
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_wait();
    logic [8:0] exp_v [5];
    exp_v[0] = 9'b111100100; exp_v[1] = 9'b111100110; exp_v[2] = 9'b111100110;
    exp_v[3] = 9'b000000000; exp_v[4] = 9'b000000000;
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_taken = (i == 1);
      RST      = (i == 3);
      if (i == 4) begin mem_req = 1'b0; mem_ready = 1'b1; end
      #2;
      checks++;
      if (obs() !== exp_v[i]) begin
        failures++; $display("FAIL reset_mid_wait_c%0d got=%b exp=%b", i, obs(), exp_v[i]);
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  // Reference model: tracks the pipeline situation (waiting on memory, owed
  // redirect, remaining flush cycles, bubble just inserted) cycle by cycle.
  task automatic test_random();
    bit waiting = 0, owed = 0, bubbled = 0, tout = 0;
    int waited = 0, flush_left = 0;
    bit e_mem, e_fl, e_lu, e_to, hit;
    logic [1:0] e_hz;
    logic [8:0] exp_v;
    for (int n = 0; n < 800; n++) begin
      RST         = (n == 0) || ($urandom_range(0, 149) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = ($urandom_range(0, 3) != 0);
      id_use_rs2  = ($urandom_range(0, 1) != 0);
      ex_rd       = 5'($urandom_range(0, 3));
      ex_op       = ($urandom_range(0, 1) != 0) ? OP_LOAD : 7'($urandom);
      ex_regWrite = ($urandom_range(0, 3) != 0);
      br_taken    = ($urandom_range(0, 6) == 0);
      mem_req     = ($urandom_range(0, 4) == 0);
      mem_ready   = ($urandom_range(0, (n < 400) ? 2 : 14) == 0);

      hit = (ex_op == OP_LOAD) && ex_regWrite && (ex_rd != 5'd0) &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      e_hz = waiting ? 2'd2 : (flush_left > 0) ? 2'd3 : bubbled ? 2'd1 : 2'd0;
      e_mem = 0; e_fl = 0; e_lu = 0; e_to = tout;
      if (RST) begin
        waiting = 0; owed = 0; bubbled = 0; tout = 0; waited = 0; flush_left = 0;
        e_to = 0; e_hz = 2'd0;
      end else if (waiting) begin
        if (mem_ready) begin
          if (owed || br_taken) begin e_fl = 1; flush_left = FC - 1; end
          waiting = 0; owed = 0;
        end else if (waited >= MW) begin
          e_to = 1; tout = 1; waiting = 0; owed = 0;
        end else begin
          e_mem = 1; waited++; owed = owed || br_taken;
        end
      end else if (mem_req && !mem_ready) begin
        e_mem = 1; waiting = 1; waited = 1; owed = br_taken; flush_left = 0; bubbled = 0;
      end else if (br_taken) begin
        e_fl = 1; flush_left = FC - 1; bubbled = 0;
      end else if (flush_left > 0) begin
        e_fl = 1; flush_left--;
      end else if (hit && !bubbled) begin
        e_lu = 1; bubbled = 1;
      end else begin
        bubbled = 0;
      end
      exp_v = {e_mem | e_lu, e_mem | e_lu, e_mem, e_mem, e_fl | e_lu, e_fl, e_to, e_hz};
      #2;
      checks++;
      if (obs() !== exp_v) begin
        failures++; $display("FAIL random_n%0d got=%b exp=%b", n, obs(), exp_v);
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle_inputs();
    RST = 1'b1; @(negedge CLK); RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_load_use(5'(k + 1)); @(negedge CLK);
      idle_inputs();           @(negedge CLK);
    end
    mem_req = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge CLK);
    mem_ready = 1'b1; @(negedge CLK);
    idle_inputs();    @(negedge CLK);
    br_taken = 1'b1;  @(negedge CLK);
    br_taken = 1'b0;
    for (int k = 0; k < FC + 1; k++) @(negedge CLK);
    #2;
    checks++;
    if (load_stall_cnt !== 32'd3) begin
      failures++; $display("FAIL perf_load got=%0d exp=3", load_stall_cnt);
    end
    checks++;
    if (mem_stall_cnt !== 32'd5) begin
      failures++; $display("FAIL perf_mem got=%0d exp=5", mem_stall_cnt);
    end
    checks++;
    if (flush_cnt_total !== 32'(FC)) begin
      failures++; $display("FAIL perf_flush got=%0d exp=%0d", flush_cnt_total, FC);
    end
    @(negedge CLK);
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
